mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N_CLIENTS, default 4, number of DSP clients sharing one multiplier.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum RUN cycles before a grant is forcibly revoked.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  N_CLIENTS  per-client level request; held until matching done.
REQ-006 SHALL have port start  output  N_CLIENTS  one-cycle start pulse to the granted client.
REQ-007 SHALL have port finish  input  N_CLIENTS  client finish pulse.
REQ-008 SHALL have port cli_a, cli_b  input  N_CLIENTS x 32  per-client multiplier operands.
REQ-009 SHALL have port mult_a, mult_b  output  32  operands to the shared multiplier.
REQ-010 SHALL have port mult_p  input  64  shared product, wired straight to all clients outside this block; unused internally except as pass-through reference.
REQ-011 SHALL have port done  output  N_CLIENTS  one-cycle completion pulse per client.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port grant_id  output  $clog2(N_CLIENTS)  index of current or last grant.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 SHALL implement states IDLE, START, RUN, DONE.
REQ-016 IDLE: if any req bit set, SHALL latch grant_id = first requesting index at or after rr_ptr (circular) and go to START; else stay.
REQ-017 START: SHALL assert start[grant_id] for exactly this cycle, clear watchdog counter, go to RUN.
REQ-018 RUN: SHALL drive mult_a = cli_a[grant_id], mult_b = cli_b[grant_id] combinationally; other states drive 0 on both.
REQ-019 RUN: finish[grant_id]=1 SHALL go to DONE; otherwise counter increments; counter reaching TIMEOUT SHALL go to DONE and pulse timeout_err in the DONE cycle.
REQ-020 DONE: SHALL pulse done[grant_id], set rr_ptr = (grant_id+1) mod N_CLIENTS, go to IDLE.
REQ-021 finish from non-granted clients SHALL be ignored; finish outside RUN SHALL be ignored.
REQ-022 req dropping during START/RUN SHALL NOT abort the operation; done still pulses.
REQ-023 Minimum turnaround per grant: 1 (IDLE) + 1 (START) + k (RUN) + 1 (DONE) cycles; back-to-back requests SHALL rotate fairly, no client granted twice while another waits.
REQ-024 At most one bit of start, done SHALL be set in any cycle.
REQ-025 Counter width SHALL be $clog2(TIMEOUT+1); no wrap-around possible.

Reset
REQ-026 rst SHALL force IDLE, rr_ptr=0, grant_id=0, counter=0 on the next edge, including mid-RUN.
REQ-027 During/after reset: start=0, done=0, busy=0, timeout_err=0, mult_a=mult_b=0.
REQ-028 Clients SHALL share the same rst; no abort handshake to an in-flight client is generated.

Structure
REQ-029 Package dsp_pkg SHALL hold the state enum type, default N_CLIENTS and TIMEOUT constants.
REQ-030 Round-robin selection SHALL be one sub-module rr_pick (inputs req, ptr; outputs valid, index), purely combinational.
REQ-031 Operand mux and FSM SHALL reside in mult_arbiter; target 150-300 RTL lines total.

Verification
REQ-032 Single triangle client on port 0, x=6000: start[0] one cycle after IDLE sees req; mult_a=6000, mult_b=699 in RUN; client y=4194000; done[0] pulses; total 1+1+4+1 cycles.
REQ-033 req=4'b1111 held continuously: grant order 0,1,2,3,0; each grant separated by DONE/IDLE cycle; never two start bits at once.
REQ-034 Client 2 never asserts finish, TIMEOUT=255: RUN lasts 255 cycles, then done[2] and timeout_err both pulse, rr_ptr=3.
REQ-035 rst asserted during RUN of client 1: next cycle busy=0, mult_a=mult_b=0, grant_id=0; following req=4'b0010 grants client 1 cleanly.
REQ-036 Spurious finish[3] while client 0 granted: ignored, client 0 completes normally, no done[3].
REQ-037 req[1] dropped mid-RUN: operation completes, done[1] pulses, no re-grant to client 1.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared types and default sizing for the DSP multiplier arbiter.
package dsp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_N_CLIENTS = 4;
    localparam int DEF_TIMEOUT   = 255;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, circularly.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] index
);

    int            s;
    logic [IW-1:0] j;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        s     = 0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = int'(ptr) + i;
            if (s >= N) s = s - N;
            j = IW'(s);
            if (req[j]) begin
                valid = 1'b1;
                index = j;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates one shared 32x32 multiplier among N_CLIENTS DSP clients with a
// START/RUN/DONE handshake, round-robin fairness and a RUN watchdog.
module mult_arbiter
    import dsp_pkg::*;
#(
    parameter int N_CLIENTS = DEF_N_CLIENTS,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CLIENTS-1:0]       req,
    output logic [N_CLIENTS-1:0]       start,
    input  logic [N_CLIENTS-1:0]       finish,
    input  logic [N_CLIENTS-1:0][31:0] cli_a,
    input  logic [N_CLIENTS-1:0][31:0] cli_b,
    output logic [31:0]                mult_a,
    output logic [31:0]                mult_b,
    input  logic [63:0]                mult_p,
    output logic [N_CLIENTS-1:0]       done,
    output logic                       busy,
    output logic [IW-1:0]              grant_id,
    output logic                       timeout_err
);

    state_t        state, state_d;
    logic [IW-1:0] rr_ptr, ptr_d, grant_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          to_flag, to_d;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    // The product goes straight to the clients; nothing here consumes it.
    logic mult_p_unused;
    assign mult_p_unused = ^mult_p;

    rr_pick #(.N(N_CLIENTS), .IW(IW)) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            cnt      <= '0;
            to_flag  <= 1'b0;
        end else begin
            state    <= state_d;
            rr_ptr   <= ptr_d;
            grant_id <= grant_d;
            cnt      <= cnt_d;
            to_flag  <= to_d;
        end
    end

    always_comb begin
        state_d     = state;
        ptr_d       = rr_ptr;
        grant_d     = grant_id;
        cnt_d       = cnt;
        to_d        = to_flag;
        start       = '0;
        done        = '0;
        timeout_err = 1'b0;
        mult_a      = '0;
        mult_b      = '0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = START;
                end
            end
            START: begin
                start[grant_id] = 1'b1;
                cnt_d           = '0;
                to_d            = 1'b0;
                state_d         = RUN;
            end
            RUN: begin
                mult_a = cli_a[grant_id];
                mult_b = cli_b[grant_id];
                if (finish[grant_id]) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                    // Counter hits TIMEOUT on this edge, so RUN lasts exactly TIMEOUT cycles.
                    if (cnt == CW'(TIMEOUT - 1)) begin
                        to_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done[grant_id] = 1'b1;
                timeout_err    = to_flag;
                ptr_d          = (grant_id == IW'(N_CLIENTS - 1)) ? '0 : grant_id + IW'(1);
                to_d           = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (4 clients, TIMEOUT 255).
module tb_mult_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req, start, finish, done;
    logic [3:0][31:0] cli_a, cli_b;
    logic [31:0]      mult_a, mult_b;
    logic [63:0]      mult_p;
    logic             busy, timeout_err;
    logic [1:0]       grant_id;

    int checks = 0;
    int errors = 0;
    int run_cnt;
    logic onehot_bad = 1'b0;
    logic [63:0] y;
    int order [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    assign mult_p = {32'b0, mult_a} * {32'b0, mult_b};

    mult_arbiter #(.N_CLIENTS(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .req(req), .start(start), .finish(finish),
        .cli_a(cli_a), .cli_b(cli_b), .mult_a(mult_a), .mult_b(mult_b),
        .mult_p(mult_p), .done(done), .busy(busy), .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    always @(negedge clk)
        if (!rst && ($countones(start) > 1 || $countones(done) > 1)) onehot_bad = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; finish = '0; cli_a = '0; cli_b = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_done", done, 0);
        check("rst_gid", grant_id, 0);
        check("rst_to", timeout_err, 0);
        check("rst_ma", mult_a, 0);
        check("rst_mb", mult_b, 0);
        rst = 1'b0;
        tick();

        // Triangle client on port 0: 1 IDLE + 1 START + 4 RUN + 1 DONE.
        cli_a[0] = 32'd6000; cli_b[0] = 32'd699; req = 4'b0001;
        tick();
        check("t32_start", start, 4'b0001);
        check("t32_gid", grant_id, 0);
        tick();
        check("t32_ma", mult_a, 6000);
        check("t32_mb", mult_b, 699);
        check("t32_start_off", start, 0);
        y = mult_p;
        check("t32_y", y, 64'd4194000);
        tick(); tick(); tick();
        check("t32_run4_busy", busy, 1);
        finish = 4'b0001;
        tick();
        check("t32_done", done, 4'b0001);
        check("t32_to", timeout_err, 0);
        finish = '0; req = '0;
        tick();
        check("t32_idle", busy, 0);
        check("t32_done_off", done, 0);

        // Continuous requests from reset pointer: rotate 0,1,2,3,0.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t33_start", start, 64'(1) << order[k]);
            check("t33_gid", grant_id, 64'(order[k]));
            tick();
            finish = 4'(1 << order[k]);
            tick();
            check("t33_done", done, 64'(1) << order[k]);
            finish = '0;
            if (k == 4) req = '0;
            tick();
            check("t33_gap", busy, 0);
        end

        // Client 2 never finishes: watchdog revokes after 255 RUN cycles.
        req = 4'b0100;
        tick();
        check("t34_start", start, 4'b0100);
        tick();
        run_cnt = 0;
        while (done == 0 && run_cnt < 400) begin
            run_cnt++;
            tick();
        end
        check("t34_runlen", run_cnt, 255);
        check("t34_done", done, 4'b0100);
        check("t34_to", timeout_err, 1);
        req = 4'b1001;
        tick();
        check("t34_to_off", timeout_err, 0);
        tick();
        check("t34_next_gid", grant_id, 3);
        check("t34_next_start", start, 4'b1000);
        tick();
        finish = 4'b1000; req = '0;
        tick();
        check("t34_done3", done, 4'b1000);
        finish = '0;
        tick();

        // Reset mid-RUN of client 1, then a clean re-grant.
        req = 4'b0010; cli_a[1] = 32'd123; cli_b[1] = 32'd45;
        tick(); tick();
        check("t35_ma_run", mult_a, 123);
        rst = 1'b1;
        tick();
        check("t35_busy", busy, 0);
        check("t35_ma", mult_a, 0);
        check("t35_mb", mult_b, 0);
        check("t35_gid", grant_id, 0);
        rst = 1'b0;
        tick();
        check("t35_start", start, 4'b0010);
        check("t35_gid1", grant_id, 1);
        tick();
        finish = 4'b0010; req = '0;
        tick();
        check("t35_done", done, 4'b0010);
        finish = '0;
        tick();

        // Spurious finish[3] while client 0 runs.
        req = 4'b0001;
        tick();
        check("t36_start", start, 4'b0001);
        tick();
        finish = 4'b1000;
        tick();
        check("t36_busy", busy, 1);
        check("t36_nodone", done, 0);
        finish = 4'b0001;
        tick();
        check("t36_done", done, 4'b0001);
        finish = '0; req = '0;
        tick();

        // req[1] dropped mid-RUN: still completes, no re-grant.
        req = 4'b0010;
        tick(); tick();
        req = '0;
        tick();
        check("t37_busy", busy, 1);
        finish = 4'b0010;
        tick();
        check("t37_done", done, 4'b0010);
        finish = '0;
        tick(); tick();
        check("t37_idle", busy, 0);
        check("t37_nostart", start, 0);

        check("onehot", onehot_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
